// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures retired instructions from a multi-slot commit port into a FIFO.
//   The FIFO is drained one entry per cycle by a trace consumer. A live CSR
//   view is also provided, and it freezes while the core drains after an
//   exception.
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   in_valid/in_pc/in_insn/
//   in_pc_next                      NRET commit slots, slot 0 oldest
//   out_valid/out_ready/out_*       head entry, valid/ready handshake
//   occupancy                       entries currently held
//   overflow                        sticky: a whole commit group was dropped
//   commit_count                    commits observed since reset (incl. dropped)
//   drain                           freeze the CSR view while high
//   csr_mtvec_i/csr_mepc_i          live CSR values
//   csr_mtvec_o/csr_mepc_o          passthrough, or snapshot while draining
module commit_trace_buffer #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRET-1:0]          in_valid,
    input  logic [NRET*32-1:0]       in_pc,
    input  logic [NRET*32-1:0]       in_insn,
    input  logic [NRET*32-1:0]       in_pc_next,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_insn,
    output logic [31:0]              out_pc_next,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [63:0]              commit_count,
    input  logic                     drain,
    input  logic [31:0]              csr_mtvec_i,
    input  logic [31:0]              csr_mepc_i,
    output logic [31:0]              csr_mtvec_o,
    output logic [31:0]              csr_mepc_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccW = $clog2(DEPTH) + 1;

    // Entry storage (data is don't-care while empty, so it is not reset)
    logic [31:0] pc_mem_q      [DEPTH];
    logic [31:0] insn_mem_q    [DEPTH];
    logic [31:0] pc_next_mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic            overflow_q, overflow_d;
    logic [63:0]     count_q, count_d;
    logic [31:0]     mtvec_snap_q, mepc_snap_q;

    int unsigned     grp_size;
    int unsigned     free_slots;
    logic            enq_ok;
    logic            deq;
    logic [PtrW-1:0] wr_idx [NRET];

    // Compaction: each valid slot lands at wr_ptr + (number of valid slots
    // below it), so invalid slots leave no hole.
    always_comb begin
        grp_size = 0;
        for (int i = 0; i < NRET; i++) begin
            wr_idx[i] = PtrW'((32'(wr_ptr_q) + grp_size) % DEPTH);
            if (in_valid[i]) begin
                grp_size = grp_size + 1;
            end
        end
    end

    always_comb begin
        // Space is judged on the pre-edge occupancy; a dequeue in the same
        // cycle does not make room for the incoming group.
        free_slots = DEPTH - 32'(occ_q);
        enq_ok     = (grp_size <= free_slots);
        deq        = (occ_q != '0) && out_ready;

        occ_d      = OccW'(32'(occ_q) + (enq_ok ? grp_size : 32'd0) - (deq ? 32'd1 : 32'd0));
        wr_ptr_d   = enq_ok ? PtrW'((32'(wr_ptr_q) + grp_size) % DEPTH) : wr_ptr_q;
        rd_ptr_d   = deq ? PtrW'((32'(rd_ptr_q) + 32'd1) % DEPTH) : rd_ptr_q;
        overflow_d = overflow_q | ~enq_ok;
        count_d    = count_q + 64'(grp_size);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
            mtvec_snap_q <= '0;
            mepc_snap_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            if (!drain) begin
                mtvec_snap_q <= csr_mtvec_i;
                mepc_snap_q  <= csr_mepc_i;
            end
        end
    end

    // A dropped group writes nothing, so the FIFO never holds a partial group.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRET; i++) begin
            if (!reset && enq_ok && in_valid[i]) begin
                pc_mem_q[wr_idx[i]]      <= in_pc[32*i +: 32];
                insn_mem_q[wr_idx[i]]    <= in_insn[32*i +: 32];
                pc_next_mem_q[wr_idx[i]] <= in_pc_next[32*i +: 32];
            end
        end
    end

    assign out_valid    = (occ_q != '0);
    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign out_insn     = insn_mem_q[rd_ptr_q];
    assign out_pc_next  = pc_next_mem_q[rd_ptr_q];
    assign occupancy    = occ_q;
    assign overflow     = overflow_q;
    assign commit_count = count_q;

    assign csr_mtvec_o  = drain ? mtvec_snap_q : csr_mtvec_i;
    assign csr_mepc_o   = drain ? mepc_snap_q  : csr_mepc_i;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  in_valid = '0;
    logic [63:0] in_pc = '0, in_insn = '0, in_pc_next = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_insn, out_pc_next;
    logic [3:0]  occupancy;
    logic        overflow;
    logic [63:0] commit_count;
    logic        drain = 1'b0;
    logic [31:0] csr_mtvec_i = '0, csr_mepc_i = '0;
    logic [31:0] csr_mtvec_o, csr_mepc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.NRET(2), .DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_pc_next(in_pc_next),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_pc_next(out_pc_next),
        .occupancy(occupancy), .overflow(overflow), .commit_count(commit_count),
        .drain(drain),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // insn = ~pc and pc_next = pc + 4 so every field is predictable from pc
    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
        in_valid   = v;
        in_pc      = {p1, p0};
        in_insn    = {~p1, ~p0};
        in_pc_next = {p1 + 32'd4, p0 + 32'd4};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drain = 1'b1;
        csr_mepc_i = 32'hDEAD_BEEF;
        csr_mtvec_i = 32'h1234_5678;
        drive(2'b11, 32'h10, 32'h14);
        step();
        step();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (commit_count !== 64'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", commit_count); end
        checks++; if (csr_mepc_o !== 32'h0) begin errors++; $display("FAIL reset_snap_mepc: got %h expected 0", csr_mepc_o); end
        drain = 1'b0;
        #1;
        checks++; if (csr_mtvec_o !== 32'h1234_5678) begin errors++; $display("FAIL reset_pass_mtvec: got %h expected 12345678", csr_mtvec_o); end
        drive(2'b00, 32'h0, 32'h0);
        reset = 1'b0;
        step();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_ignore_valid: got %0d expected 0", occupancy); end
    endtask

    task automatic test_order();
        do_reset();
        out_ready = 1'b1;
        drive(2'b10, 32'h0, 32'h100);
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL order_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL order_pc0: got %h expected 100", out_pc); end
        checks++; if (out_insn !== ~32'h100) begin errors++; $display("FAIL order_insn0: got %h expected %h", out_insn, ~32'h100); end
        drive(2'b11, 32'h104, 32'h108);
        step();
        checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL order_pc1: got %h expected 104", out_pc); end
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL order_occ: got %0d expected 2", occupancy); end
        drive(2'b00, 32'h0, 32'h0);
        step();
        checks++; if (out_pc !== 32'h108) begin errors++; $display("FAIL order_pc2: got %h expected 108", out_pc); end
        checks++; if (out_pc_next !== 32'h10C) begin errors++; $display("FAIL order_pcnext2: got %h expected 10c", out_pc_next); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_empty: got %b expected 0", out_valid); end
        checks++; if (commit_count !== 64'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", commit_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 32'h2000 + 32'(16 * c), 32'h2008 + 32'(16 * c));
            step();
        end
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ: got %0d expected 8", occupancy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b expected 0", overflow); end
        drive(2'b01, 32'h3000, 32'h0);
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL drop_occ: got %0d expected 8", occupancy); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf: got %b expected 1", overflow); end
        checks++; if (commit_count !== 64'd9) begin errors++; $display("FAIL drop_count: got %0d expected 9", commit_count); end
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        // Empty it: entries come out as 0x2000, 0x2008, 0x2010 ... in order
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (out_pc !== 32'h2000 + 32'(8 * j)) begin
                errors++;
                $display("FAIL full_drain_pc[%0d]: got %h expected %h", j, out_pc, 32'h2000 + 32'(8 * j));
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_drop_with_dequeue();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 32'h4000 + 32'(8 * c), 32'h4004 + 32'(8 * c));
            step();
        end
        drive(2'b01, 32'h4018, 32'h0);
        step();
        checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL dq_occ7: got %0d expected 7", occupancy); end
        drive(2'b11, 32'h5000, 32'h5004);
        out_ready = 1'b1;
        step();
        drive(2'b00, 32'h0, 32'h0);
        out_ready = 1'b0;
        checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL dq_occ6: got %0d expected 6", occupancy); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL dq_ovf: got %b expected 1", overflow); end
        checks++; if (commit_count !== 64'd9) begin errors++; $display("FAIL dq_count: got %0d expected 9", commit_count); end
        checks++; if (out_pc !== 32'h4004) begin errors++; $display("FAIL dq_head: got %h expected 4004", out_pc); end
    endtask

    task automatic test_wrap_stream();
        logic [31:0] q[$];
        logic [31:0] held_pc;
        logic [31:0] new_pc;
        logic        prev_stall;
        logic        push;
        int          sent;
        int          got;
        do_reset();
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        held_pc = '0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            out_ready = (cyc % 2 == 0);
            push = (sent < 20) && (q.size() < 8);
            new_pc = 32'h6000 + 32'(4 * sent);
            drive(push ? 2'b01 : 2'b00, new_pc, 32'h0);
            if (q.size() > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== q[0]) begin
                    errors++;
                    $display("FAIL stream_head cyc %0d: got valid=%b pc=%h expected valid=1 pc=%h",
                             cyc, out_valid, out_pc, q[0]);
                end
                if (prev_stall) begin
                    checks++;
                    if (out_pc !== held_pc) begin
                        errors++;
                        $display("FAIL stream_hold cyc %0d: got %h expected %h", cyc, out_pc, held_pc);
                    end
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_empty cyc %0d: got %b expected 0", cyc, out_valid);
                end
            end
            prev_stall = (q.size() > 0) && !out_ready;
            held_pc = (q.size() > 0) ? q[0] : 32'h0;
            step();
            if (out_ready && q.size() > 0) begin
                void'(q.pop_front());
                got++;
            end
            if (push) begin
                q.push_back(new_pc);
                sent++;
            end
        end
        drive(2'b00, 32'h0, 32'h0);
        out_ready = 1'b0;
        checks++; if (got !== 20) begin errors++; $display("FAIL stream_received: got %0d expected 20", got); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf: got %b expected 0", overflow); end
        checks++; if (commit_count !== 64'd20) begin errors++; $display("FAIL stream_count: got %0d expected 20", commit_count); end
    endtask

    task automatic test_csr_drain();
        do_reset();
        drain = 1'b0;
        csr_mepc_i = 32'h200;
        csr_mtvec_i = 32'h80;
        #1;
        checks++; if (csr_mepc_o !== 32'h200) begin errors++; $display("FAIL csr_pass: got %h expected 200", csr_mepc_o); end
        step();
        drain = 1'b1;
        #1;
        checks++; if (csr_mepc_o !== 32'h200) begin errors++; $display("FAIL csr_drain_start: got %h expected 200", csr_mepc_o); end
        csr_mepc_i = 32'h300;
        csr_mtvec_i = 32'h90;
        #1;
        checks++; if (csr_mepc_o !== 32'h200) begin errors++; $display("FAIL csr_frozen_mepc: got %h expected 200", csr_mepc_o); end
        checks++; if (csr_mtvec_o !== 32'h80) begin errors++; $display("FAIL csr_frozen_mtvec: got %h expected 80", csr_mtvec_o); end
        step();
        step();
        checks++; if (csr_mepc_o !== 32'h200) begin errors++; $display("FAIL csr_hold: got %h expected 200", csr_mepc_o); end
        drain = 1'b0;
        #1;
        checks++; if (csr_mepc_o !== 32'h300) begin errors++; $display("FAIL csr_release_mepc: got %h expected 300", csr_mepc_o); end
        checks++; if (csr_mtvec_o !== 32'h90) begin errors++; $display("FAIL csr_release_mtvec: got %h expected 90", csr_mtvec_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 32'h7000 + 32'(8 * c), 32'h7004 + 32'(8 * c));
            step();
        end
        drive(2'b01, 32'h7100, 32'h0);
        step();
        drive(2'b00, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL mid_occ5: got %0d expected 5", occupancy); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf1: got %b expected 1", overflow); end
        reset = 1'b1;
        drive(2'b11, 32'h7200, 32'h7204);
        step();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL mid_occ0: got %0d expected 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf0: got %b expected 0", overflow); end
        checks++; if (commit_count !== 64'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", commit_count); end
        reset = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        step();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL mid_after: got %0d expected 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_overflow();
        test_drop_with_dequeue();
        test_wrap_stream();
        test_csr_drain();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter NRET, default 2, number of commit slots per cycle, range 1..4.
REQ-002 Parameter DEPTH, default 8, trace FIFO entries, power of two, DEPTH >= NRET.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  NRET  per-slot commit valid; slot 0 is the oldest commit.
REQ-006 Port in_pc  input  NRET*32  per-slot committed PC, slot i at bits [32i+31:32i].
REQ-007 Port in_insn  input  NRET*32  per-slot committed instruction word.
REQ-008 Port in_pc_next  input  NRET*32  per-slot next PC after commit.
REQ-009 Port out_valid  output  1  head entry available.
REQ-010 Port out_ready  input  1  consumer accepts head entry.
REQ-011 Port out_pc, out_insn, out_pc_next  output  32 each  head entry fields.
REQ-012 Port occupancy  output  clog2(DEPTH)+1  current entry count.
REQ-013 Port overflow  output  1  sticky: a commit group was dropped.
REQ-014 Port commit_count  output  64  total commits observed since reset.
REQ-015 Port drain  input  1  core is draining after an exception.
REQ-016 Port csr_mtvec_i, csr_mepc_i  input  32 each  live CSR values from core.
REQ-017 Port csr_mtvec_o, csr_mepc_o  output  32 each  stable CSR view for checkers.

Function
REQ-018 Each cycle, valid slots SHALL be enqueued in ascending slot order, compacted (invalid slots leave no hole).
REQ-019 Group size k = popcount(in_valid); group SHALL be enqueued whole only if k <= DEPTH - occupancy, where occupancy is the pre-edge value (a same-cycle dequeue does not free space).
REQ-020 If k > DEPTH - occupancy, no slot of that group SHALL be written and overflow SHALL set to 1 and stay 1 until reset.
REQ-021 commit_count SHALL increase by k every cycle, including dropped groups, wrapping modulo 2^64.
REQ-022 out_valid SHALL equal (occupancy != 0); out_* SHALL present the head entry from registers, no combinational path from in_* to out_*.
REQ-023 Latency: a commit enqueued into an empty buffer at edge N SHALL appear on out_* in the cycle after edge N.
REQ-024 Dequeue SHALL occur on an edge where out_valid && out_ready; out_ready with out_valid low SHALL have no effect.
REQ-025 Simultaneous enqueue of k and dequeue SHALL update occupancy by k-1 in one edge.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-027 out_* SHALL hold stable while out_valid && !out_ready.
REQ-028 When drain = 0, csr_*_o SHALL equal csr_*_i combinationally and a snapshot register SHALL capture csr_*_i each edge.
REQ-029 When drain = 1, csr_*_o SHALL equal the snapshot, and the snapshot SHALL hold.
REQ-030 Deassertion of drain SHALL return csr_*_o to passthrough in the same cycle.

Reset
REQ-031 With reset high at an edge: occupancy=0, out_valid=0, pointers=0, overflow=0, commit_count=0, snapshots=0; in_valid at that edge SHALL be ignored.
REQ-032 Reset mid-operation SHALL discard all buffered entries; out_* data values after reset are don't-care while out_valid=0.
REQ-033 csr_*_o SHALL follow REQ-028/029 during reset using the reset snapshot value 0.

Verification
REQ-034 NRET=2, in_valid=2'b10 pc1=0x100 then 2'b11 pc0=0x104 pc1=0x108, out_ready=1 -> outputs 0x100, 0x104, 0x108 in order, commit_count=3.
REQ-035 DEPTH=8, out_ready=0, 4 cycles of in_valid=2'b11 -> occupancy=8, overflow=0; fifth cycle in_valid=2'b01 -> dropped, overflow=1, occupancy=8, commit_count=9.
REQ-036 occupancy=7, in_valid=2'b11 with out_ready=1 -> group dropped, overflow=1, occupancy=6.
REQ-037 Stream 20 single commits, out_ready toggling 1/0 -> all 20 PCs out in order across pointer wrap, out_* stable while stalled.
REQ-038 csr_mepc_i=0x200, drain 0->1, csr_mepc_i changes to 0x300 -> csr_mepc_o=0x200 until drain=0, then 0x300 same cycle.
REQ-039 Reset asserted with occupancy=5, overflow=1 -> next cycle occupancy=0, out_valid=0, overflow=0, commit_count=0.
